// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the ALU / multiply-divide unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_EQ     = 5'b01010;
  localparam logic [4:0] OP_EQU    = 5'b01011;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_PASSA  = 5'b01110;
  localparam logic [4:0] OP_PASSB  = 5'b01111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4] && !op[3];
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Decode-to-writeback handshake bundle for alu_mdu.
interface alu_mdu_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/md_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider over operand magnitudes,
// one step per cycle, with sign fix-up applied on the final step.
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] mag_a_i,
  input  logic [WIDTH-1:0] mag_b_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  input  logic             step_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   d_q;
  logic [2:0]         op_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  // p_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
    rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, d_q};
    p_d      = '0;
    if (!op_q[2]) begin
      p_d = {mul_sum, p_q[WIDTH-1:1]};
    end else if (!rem_diff[WIDTH]) begin
      p_d = {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_d = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end
    prod_s = neg_q_q ? -p_d : p_d;
    quot_s = neg_q_q ? -p_d[WIDTH-1:0] : p_d[WIDTH-1:0];
    rem_s  = neg_r_q ? -p_d[2*WIDTH-1:WIDTH] : p_d[2*WIDTH-1:WIDTH];
    result_o = '0;
    case (op_q)
      3'b000:         result_o = prod_s[WIDTH-1:0];
      3'b100, 3'b101: result_o = quot_s;
      3'b110, 3'b111: result_o = rem_s;
      default:        result_o = prod_s[2*WIDTH-1:WIDTH];
    endcase
  end

  assign done_o = step_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      d_q     <= '0;
      op_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start_i) begin
      p_q     <= {{WIDTH{1'b0}}, mag_a_i};
      d_q     <= mag_b_i;
      op_q    <= op_i;
      neg_q_q <= neg_q_i;
      neg_r_q <= neg_r_i;
      cnt_q   <= CNT_W'(WIDTH - 1);
    end else if (step_i) begin
      p_q   <= p_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with registered single-cycle base ops and iterative RV32M multiply/divide,
// exposed through a valid/ready handshake that stalls decode while an iteration is in flight.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_mdu_if.slave  bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   fast_res;
  logic               div_special;
  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               md_start;
  logic               md_done;
  logic [WIDTH-1:0]   md_result;

  assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q == BUSY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign shamt         = bus.b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.op[3:0])
      4'b0000: alu_res = bus.a + bus.b;
      4'b1000: alu_res = bus.a - bus.b;
      4'b0001: alu_res = bus.a << shamt;
      4'b0010: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0101: alu_res = bus.a >> shamt;
      4'b1101: alu_res = WIDTH'($signed(bus.a) >>> shamt);
      4'b0110: alu_res = bus.a | bus.b;
      4'b0111: alu_res = bus.a & bus.b;
      4'b1010: alu_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      4'b1110: alu_res = bus.a;
      4'b1111: alu_res = bus.b;
      default: alu_res = '0;
    endcase
  end

  // Divide by zero and MIN/-1 resolve without iterating; op[1] selects rem, op[0] unsigned.
  always_comb begin
    div_special = is_muldiv(bus.op) && bus.op[2] &&
                  ((bus.b == '0) ||
                   (!bus.op[0] && bus.a == MIN_VAL && bus.b == '1));
    fast_res = '0;
    if (!bus.op[4]) begin
      fast_res = alu_res;
    end else if (div_special) begin
      if (bus.b == '0) begin
        fast_res = bus.op[1] ? bus.a : '1;
      end else begin
        fast_res = bus.op[1] ? '0 : MIN_VAL;
      end
    end
  end

  always_comb begin
    a_signed = (bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b010) ||
               (bus.op[2:0] == 3'b100) || (bus.op[2:0] == 3'b110);
    b_signed = (bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b100) ||
               (bus.op[2:0] == 3'b110);
    a_neg    = a_signed && bus.a[WIDTH-1];
    b_neg    = b_signed && bus.b[WIDTH-1];
    mag_a    = a_neg ? -bus.a : bus.a;
    mag_b    = b_neg ? -bus.b : bus.b;
  end

  assign md_start = accept && is_muldiv(bus.op) && !div_special;

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .op_i     (bus.op[2:0]),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .neg_q_i  (a_neg ^ b_neg),
    .neg_r_i  (a_neg),
    .step_i   (state_q == BUSY),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (md_start) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
            end
          end else if (state_q == DONE && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (md_done) begin
            state_q     <= DONE;
            result_q    <= md_result;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
